ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//   Initiator side of the single-port RAM bus (ena/wena/addr plus a shared tri-state data bus).
//   - Accepts single-word or burst read/write commands from a client.
//   - Sequences them onto the RAM pins, streaming write data in and read data out.
//   - Owns bus turnaround: this block and the RAM never drive data in the same cycle.
// PARAMETERS
//   AW  5   address width; RAM depth = 2**AW words, burst address wraps modulo 2**AW
//   DW  32  data width
// PORTS
//   clk        in     1   clock; all state changes on posedge
//   rst_n      in     1   asynchronous active-low reset
//   cmd_valid  in     1   command request
//   cmd_ready  out    1   high only in IDLE; command accepted on cmd_valid & cmd_ready
//   cmd_write  in     1   1 = write burst, 0 = read burst
//   cmd_addr   in     AW  start address
//   cmd_len    in     AW  burst length minus 1 (1..2**AW words)
//   wr_data    in     DW  write word
//   wr_valid   in     1   write word available
//   wr_ready   out    1   combinational, = (state==WR); beat taken on wr_valid & wr_ready
//   rd_data    out    DW  captured read word; holds until the next capture
//   rd_valid   out    1   one-cycle strobe per read word; no backpressure
//   done       out    1   one-cycle pulse, first IDLE cycle after a command completes
//   ram_ena    out    1   RAM enable (registered)
//   ram_wena   out    1   RAM write enable (registered)
//   ram_addr   out    AW  RAM address (registered)
//   ram_data   inout  DW  driven with the write register when oe=1, else 'z
// BEHAVIOUR
//   Reset:
//   - Async, immediate. State=IDLE.
//   - ram_ena, ram_wena, oe, rd_valid, done, ram_addr, rd_data, cur_addr, count all = 0.
//   - Bus released at once, also mid-burst; a partial burst is abandoned with no done pulse.
//   FSM states: IDLE, WR, RD, END.
//   IDLE:
//   - cmd_ready=1 and ram_ena=0.
//   - On accept: latch cur_addr=cmd_addr and count=cmd_len.
//   - Go to WR if cmd_write=1, else RD.
//   WR:
//   - On each accepted beat, register ram_ena=1, ram_wena=1, oe=1, ram_addr=cur_addr, data=wr_data.
//   - In a cycle with no beat, register ram_ena=0, oe=0. This cycle is a stall; the address does not advance.
//   - After each beat: cur_addr+=1 (mod 2**AW), count-=1.
//   - The beat taken with count==0 is the last; go to END.
//   - The RAM commits each word at the edge that ends its bus cycle.
//   RD:
//   - Every cycle, register ram_ena=1, ram_wena=0, oe=0, ram_addr=cur_addr; then advance as in WR.
//   - The issue made when count==0 is the last; go to END.
//   - Each issued read is on the bus for one cycle. rd_data is captured from ram_data at the closing edge.
//   - rd_valid=1 in the following cycle. Latency from issue edge to rd_valid = 2 edges.
//   - N-word read gives N consecutive rd_valid cycles.
//   END:
//   - Register ram_ena=0, ram_wena=0, oe=0.
//   - Capture the final read word if the command was a read.
//   - Set done=1, go to IDLE.
//   Turnaround and bus invariants:
//   - oe=1 only while ram_wena=1 and ram_ena=1.
//   - The END cycle plus the IDLE accept cycle guarantee at least one bus cycle with ram_ena=0 between commands.
//   Other rules:
//   - cmd_valid outside IDLE is ignored (cmd_ready=0).
//   - wr_valid outside WR is ignored.
//   - The command fields are sampled only at accept.
// TESTING
//   1. Write addr 3 len 0 data 0xDEADBEEF, then read addr 3 len 0
//      -> rd_data=0xDEADBEEF.
//      -> exactly one rd_valid, done after each command.
//   2. Write burst addr 8 len 3 (0x11,0x22,0x33,0x44) with wr_valid low on beat 2 for 2 cycles
//      -> the stall cycles show ram_ena=0.
//      -> read-back of 8..11 returns the 4 words in order.
//   3. Read burst addr 30 len 3
//      -> ram_addr sequence 30,31,0,1.
//      -> 4 consecutive rd_valid carrying the stored words.
//   4. Bus check over random mixed commands
//      -> never oe=1 while ram_ena&~ram_wena.
//      -> >=1 cycle of ram_ena=0 between consecutive commands.
//   5. rst_n low mid write burst (after beat 2)
//      -> ram_ena=0 and bus 'z in the same cycle.
//      -> no done pulse; cmd_ready=1 after release.
//   6. cmd_valid held high during a read burst
//      -> the second command is accepted only in the IDLE cycle after done.

Source files
------------

// File: rtl/ram_bus_master.sv
// ram_bus_master: initiator for a single-port RAM with a shared tri-state data bus.
// Takes single-word or burst commands, streams write beats onto the RAM pins and
// returns read words with a fixed two-edge latency. All RAM pins are registered;
// the data bus is driven only for write cycles, so the RAM and this block never
// drive the bus in the same cycle.
module ram_bus_master #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   // command channel
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   // write data stream
   input  logic [DW-1:0] wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   // read data stream
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          done,
   // RAM pins
   output logic          ram_ena,
   output logic          ram_wena,
   output logic [AW-1:0] ram_addr,
   inout  wire  [DW-1:0] ram_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_END
   } state_t;

   state_t        state_q,    state_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [AW-1:0] count_q,    count_d;
   logic          ram_ena_q,  ram_ena_d;
   logic          ram_wena_q, ram_wena_d;
   logic          oe_q,       oe_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] wdata_q,    wdata_d;
   logic [DW-1:0] rd_data_q,  rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          done_q,     done_d;
   logic          rd_on_bus;

   // State and registered RAM pins; reset releases the bus immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         count_q    <= '0;
         ram_ena_q  <= 1'b0;
         ram_wena_q <= 1'b0;
         oe_q       <= 1'b0;
         ram_addr_q <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         count_q    <= count_d;
         ram_ena_q  <= ram_ena_d;
         ram_wena_q <= ram_wena_d;
         oe_q       <= oe_d;
         ram_addr_q <= ram_addr_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
      end
   end

   // A read issued on the RAM pins occupies the bus for exactly one cycle.
   assign rd_on_bus = ram_ena_q & ~ram_wena_q;

   // Next-state, next RAM cycle and read capture.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      count_d    = count_q;
      ram_ena_d  = 1'b0;
      ram_wena_d = 1'b0;
      oe_d       = 1'b0;
      ram_addr_d = ram_addr_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;
      // Capture happens at the edge closing any read bus cycle, which also
      // covers the final word of a burst landing during the END cycle.
      rd_valid_d = rd_on_bus;
      rd_data_d  = rd_on_bus ? ram_data : rd_data_q;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cur_addr_d = cmd_addr;
               count_d    = cmd_len;
               state_d    = cmd_write ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
            wr_ready = 1'b1;
            // No beat means a stall cycle: RAM idle, address held.
            if (wr_valid) begin
               ram_ena_d  = 1'b1;
               ram_wena_d = 1'b1;
               oe_d       = 1'b1;
               ram_addr_d = cur_addr_q;
               wdata_d    = wr_data;
               cur_addr_d = cur_addr_q + AW'(1);
               count_d    = count_q - AW'(1);
               if (count_q == '0) begin
                  state_d = ST_END;
               end
            end
         end
         ST_RD: begin
            ram_ena_d  = 1'b1;
            ram_addr_d = cur_addr_q;
            cur_addr_d = cur_addr_q + AW'(1);
            count_d    = count_q - AW'(1);
            if (count_q == '0) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ram_ena  = ram_ena_q;
   assign ram_wena = ram_wena_q;
   assign ram_addr = ram_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign done     = done_q;

   assign ram_data = oe_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Testbench for ram_bus_master: a bus-level RAM on the tri-state data bus, a
// word-array reference of memory contents updated per command, directed
// vectors from a table, hand sequences for hold/reset corners, and random
// mixed commands.
module tb_ram_bus_master;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [AW-1:0] cmd_len;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          done;
   logic          ram_ena;
   logic          ram_wena;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;

   int n_tests = 0;
   int n_fail  = 0;

   ram_bus_master #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .ram_ena   (ram_ena),
      .ram_wena  (ram_wena),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'hC0DE_0000 + 32'(i * 257);
   endfunction

   // RAM on the pins: commits at the edge ending a write cycle, drives the bus
   // combinationally during a read cycle.
   logic [DW-1:0] tb_mem [DEPTH];
   logic          mem_init;
   always @(posedge clk) begin
      if (mem_init !== 1'b1) begin
         for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (ram_ena && ram_wena) begin
         tb_mem[ram_addr] <= ram_data;
      end
   end
   assign ram_data = (ram_ena && !ram_wena) ? tb_mem[ram_addr] : {DW{1'bz}};

   // Reference contents of memory, updated once per command.
   logic [DW-1:0] ref_mem [DEPTH];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one command from an IDLE negedge and follow it until done.
   task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input logic [DW-1:0] d0, input logic [DW-1:0] step,
                          input int stall_at, input int stall_n, input int stall_pct,
                          input logic hold,
                          output int n_ena, output int span, output int n_rdv,
                          output logic [AW-1:0] last_addr);
      logic [DW-1:0] rdq[$];
      int   beat, stalls, cyc, first_cyc, last_cyc;
      logic got_done;
      logic stall;
      n_ena = 0; span = 0; n_rdv = 0; last_addr = '0;
      beat = 0; stalls = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      got_done = 1'b0;
      check("accept_ready", {31'b0, cmd_ready}, 1);
      check("gap_ena", {31'b0, ram_ena}, 0);
      for (int i = 0; i <= int'(l); i++) begin
         if (wr) ref_mem[(int'(a) + i) % DEPTH] = d0 + step * 32'(i);
         else    rdq.push_back(ref_mem[(int'(a) + i) % DEPTH]);
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
      for (int b = 0; b < 400 && !got_done; b++) begin
         @(negedge clk);
         cmd_valid = hold;
         cmd_write = 1'($urandom);
         cmd_addr  = AW'($urandom);
         cmd_len   = AW'($urandom);
         cyc++;
         if (ram_ena) begin
            check("ram_addr", 32'(ram_addr), 32'((int'(a) + n_ena) % DEPTH));
            check("ram_wena", {31'b0, ram_wena}, {31'b0, wr});
            n_ena++;
            last_addr = ram_addr;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         if (rd_valid) begin
            n_rdv++;
            if (rdq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL rd_extra: got rd_valid count %0d required %0d", n_rdv, int'(l) + 1);
            end else begin
               check("rd_data", rd_data, rdq.pop_front());
            end
         end
         if (done) begin
            got_done = 1'b1;
            check("done_ena", {31'b0, ram_ena}, 0);
            check("done_ready", {31'b0, cmd_ready}, 1);
         end else begin
            check("busy_ready", {31'b0, cmd_ready}, 0);
         end
         if (wr_ready && beat <= int'(l)) begin
            stall = (beat == stall_at && stalls < stall_n) ||
                    (stall_pct > 0 && int'($urandom_range(99)) < stall_pct);
            if (stall) begin
               stalls++;
               wr_valid = 1'b0;
               wr_data  = $urandom;
            end else begin
               wr_valid = 1'b1;
               wr_data  = d0 + step * 32'(beat);
               beat++;
            end
         end else begin
            wr_valid = 1'($urandom);
            wr_data  = $urandom;
         end
      end
      wr_valid = 1'b0;
      if (!got_done) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: got no done, required done within 400 cycles");
      end
      if (first_cyc >= 0) span = last_cyc - first_cyc + 1;
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [AW-1:0] len;
      logic [DW-1:0] d0;
      logic [DW-1:0] step;
      int            stall_at;
      int            stall_n;
      int            exp_ena;
      int            exp_span;
      int            exp_rdv;
      logic [AW-1:0] exp_last;
   } vec_t;

   vec_t          tbl [6];
   int            n_ena, span, n_rdv;
   logic [AW-1:0] last_a;
   logic          r_wr;
   logic [AW-1:0] r_len;

   initial begin
      // wr addr len d0 step stall_at stall_n | ena span rdv last_addr
      tbl[0] = '{1'b1, 5'd3,  5'd0, 32'hDEADBEEF, 32'h0,  -1, 0, 1, 1, 0, 5'd3};
      tbl[1] = '{1'b0, 5'd3,  5'd0, 32'h0,        32'h0,  -1, 0, 1, 1, 1, 5'd3};
      tbl[2] = '{1'b1, 5'd8,  5'd3, 32'h11,       32'h11,  1, 2, 4, 6, 0, 5'd11};
      tbl[3] = '{1'b0, 5'd8,  5'd3, 32'h0,        32'h0,  -1, 0, 4, 4, 4, 5'd11};
      tbl[4] = '{1'b0, 5'd30, 5'd3, 32'h0,        32'h0,  -1, 0, 4, 4, 4, 5'd1};
      tbl[5] = '{1'b1, 5'd31, 5'd1, 32'h5,        32'h1,  -1, 0, 2, 2, 0, 5'd0};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_ready",    {31'b0, cmd_ready}, 1);
      check("rst_wr_ready", {31'b0, wr_ready},  0);
      check("rst_ena",      {31'b0, ram_ena},   0);
      check("rst_wena",     {31'b0, ram_wena},  0);
      check("rst_addr",     32'(ram_addr),      0);
      check("rst_rd_data",  rd_data,            0);
      check("rst_rd_valid", {31'b0, rd_valid},  0);
      check("rst_done",     {31'b0, done},      0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].d0, tbl[i].step,
                 tbl[i].stall_at, tbl[i].stall_n, 0, 1'b0, n_ena, span, n_rdv, last_a);
         check($sformatf("vec%0d_ena_count", i), 32'(n_ena), 32'(tbl[i].exp_ena));
         check($sformatf("vec%0d_span", i),      32'(span),  32'(tbl[i].exp_span));
         check($sformatf("vec%0d_rd_count", i),  32'(n_rdv), 32'(tbl[i].exp_rdv));
         check($sformatf("vec%0d_last_addr", i), 32'(last_a), 32'(tbl[i].exp_last));
      end

      // cmd_valid held through a read burst: next command only after done
      run_cmd(1'b0, 5'd0, 5'd2, 32'h0, 32'h0, -1, 0, 0, 1'b1, n_ena, span, n_rdv, last_a);
      check("hold_rd_count", 32'(n_rdv), 3);
      run_cmd(1'b1, 5'd20, 5'd0, 32'h6666_0000, 32'h0, -1, 0, 0, 1'b0, n_ena, span, n_rdv, last_a);
      check("hold_wr_addr", 32'(last_a), 20);

      // Random mixed commands
      for (int k = 0; k < 40; k++) begin
         r_wr = 1'($urandom);
         case ($urandom_range(9))
            0, 1:    r_len = AW'(DEPTH - 1);
            2, 3, 4: r_len = AW'($urandom_range(7));
            default: r_len = AW'($urandom_range(3));
         endcase
         run_cmd(r_wr, AW'($urandom), r_len, $urandom, $urandom, -1, 0, r_wr ? 30 : 0,
                 1'($urandom_range(3) == 0), n_ena, span, n_rdv, last_a);
         check("rand_ena_count", 32'(n_ena), 32'(int'(r_len) + 1));
         check("rand_rd_count",  32'(n_rdv), r_wr ? 32'd0 : 32'(int'(r_len) + 1));
      end

      // Whole-memory sweep read
      run_cmd(1'b0, 5'd0, 5'd31, 32'h0, 32'h0, -1, 0, 0, 1'b0, n_ena, span, n_rdv, last_a);
      check("sweep_rd_count", 32'(n_rdv), 32);

      // Reset in the middle of a write burst, while the second beat is on the bus
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd16; cmd_len = 5'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid = 1'b1; wr_data = 32'hA0A0_0001;
      @(negedge clk);
      check("mid_beat1_ena", {31'b0, ram_ena}, 1);
      wr_data = 32'hA0A0_0002;
      @(negedge clk);
      check("mid_beat2_ena",  {31'b0, ram_ena}, 1);
      check("mid_beat2_addr", 32'(ram_addr), 17);
      rst_n = 1'b0;
      #1;
      wr_valid = 1'b0;
      check("mid_rst_ena",     {31'b0, ram_ena},  0);
      check("mid_rst_wena",    {31'b0, ram_wena}, 0);
      check("mid_rst_bus_off", {31'b0, (ram_data !== 32'hA0A0_0002)}, 1);
      ref_mem[16] = 32'hA0A0_0001;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_no_done", {31'b0, done}, 0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_no_done", {31'b0, done},      0);
         check("post_rst_ready",   {31'b0, cmd_ready}, 1);
         check("post_rst_ena",     {31'b0, ram_ena},   0);
      end
      run_cmd(1'b0, 5'd16, 5'd1, 32'h0, 32'h0, -1, 0, 0, 1'b0, n_ena, span, n_rdv, last_a);
      check("post_rst_rd_count", 32'(n_rdv), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
